down_timer: RTL

- Loadable, parameterised down-counter/timer; the count-down counterpart of the team's up-counter.
- Software or an FSM loads a start value, pulses `cnt` to decrement, and receives a one-cycle `done` pulse when the count reaches zero.
- Used as a delay or interval generator next to the up-counter in lab datapaths.
- Count bits are bit-sliced: one msdff per bit, next-state from a borrow chain.

---
 rtl/down_timer.sv | 117 +++++++++++
 1 files changed

// File: rtl/down_timer.sv
// down_timer: loadable n-bit down-counter / interval timer with one-cycle done pulse.
// Optional build macro DOWN_TIMER_AUTO_RELOAD_EN: on expiry the count reloads the last
// loaded value and keeps running periodically instead of stopping in EXPIRED.
module down_timer #(
    parameter int unsigned n = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ld,
    input  logic [n-1:0] din,
    input  logic         cnt,
    input  logic         stop,
    output logic [n-1:0] out,
    output logic         busy,
    output logic         tc,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t       state;
    logic         dec;
    logic         at_one;
    logic [n-1:0] toggle;
    logic [n-1:0] out_d;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    logic [n-1:0] reload;
    logic         done_q;
`endif

    // a decrement happens only in RUN when no higher-priority strobe is present
    assign at_one = (out == n'(1));
    assign dec    = (state == RUN) & cnt & ~ld & ~stop;
    assign busy   = (state == RUN);
    assign tc     = cnt & busy & at_one;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    assign done = done_q;
`else
    assign done = (state == EXPIRED);
`endif

    // borrow chain: bit k toggles when decrementing and all lower bits are zero
    always_comb begin
        logic lower_zero;
        lower_zero = 1'b1;
        toggle     = '0;
        for (int k = 0; k < int'(n); k++) begin
            toggle[k]  = dec & lower_zero;
            lower_zero = lower_zero & ~out[k];
        end
    end

    // next count: load wins, then reload at expiry (periodic build), else borrow-chain result
    always_comb begin
        out_d = out ^ toggle;
        if (ld) begin
            out_d = din;
        end
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        else if (dec && at_one) begin
            out_d = reload;
        end
`endif
    end

    // count register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else begin
            out <= out_d;
        end
    end

    // control FSM with priority ld > stop > cnt
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            reload <= '0;
            done_q <= 1'b0;
`endif
        end else if (ld) begin
            state  <= (din != '0) ? RUN : IDLE;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            reload <= din;
            done_q <= 1'b0;
`endif
        end else begin
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            done_q <= 1'b0;
`endif
            case (state)
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (cnt && at_one) begin
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                        done_q <= 1'b1;
`else
                        state  <= EXPIRED;
`endif
                    end
                end
                EXPIRED: state <= IDLE;
                default: state <= state;
            endcase
        end
    end

endmodule
